read_guard: RTL

- Monitors the AXI read path (AR and R channels) between a manager and one guarded subordinate.
- It is the read-direction counterpart of write_guard; slv_guard instantiates one per subordinate.
- It snoops the handshakes passively, tracks up to MaxRdTxns outstanding reads, and checks each latency phase against a register-programmed budget.
- On the first violation it latches the cause and ID, raises irq_o, and requests a subordinate reset.

---
 rtl/read_guard.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/read_guard.sv
// Passive AXI read-path watchdog: times each read phase against budgets, latches the first violation
// and drives a subordinate reset handshake. req_i = {ar_valid, ar_id, r_ready}; rsp_i = {ar_ready, r_valid, r_id, r_last}.
module read_guard #(
  parameter int unsigned MaxRdTxns = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned CntWidth  = 10,
  localparam int unsigned ReqWidth = IdWidth + 2,
  localparam int unsigned RspWidth = IdWidth + 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                guard_ena_i,
  input  logic [ReqWidth-1:0] req_i,
  input  logic [RspWidth-1:0] rsp_i,
  input  logic [CntWidth-1:0] budget_arvld_arrdy_i,
  input  logic [CntWidth-1:0] budget_arvld_rvld_i,
  input  logic [CntWidth-1:0] budget_rvld_rrdy_i,
  input  logic [CntWidth-1:0] budget_rvld_rlast_i,
  input  logic                irq_clr_i,
  output logic                irq_o,
  output logic                rst_req_o,
  input  logic                rst_stat_i,
  output logic [4:0]          cause_o,
  output logic [IdWidth-1:0]  cause_id_o,
  output logic                overflow_o
);

  localparam int unsigned OldWidth = $clog2(MaxRdTxns + 1);
  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [OldWidth-1:0] OldOne = OldWidth'(1);

  typedef enum logic [1:0] {MONITOR, RST_REQ, RST_WAIT} state_e;
  typedef enum logic {WAIT_FIRST, IN_BURST} phase_e;

  logic               ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [IdWidth-1:0] ar_id, r_id;

  assign {ar_valid, ar_id, r_ready}       = req_i;
  assign {ar_ready, r_valid, r_id, r_last} = rsp_i;

  state_e               state_reg, state_next;
  logic                 irq_reg, overflow_reg, detect_reg;
  logic [4:0]           cause_reg;
  logic [IdWidth-1:0]   cause_id_reg;
  logic [CntWidth-1:0]  ar_cnt_reg, r_cnt_reg;

  logic                 ent_valid_reg [MaxRdTxns];
  logic [IdWidth-1:0]   ent_id_reg    [MaxRdTxns];
  phase_e               ent_phase_reg [MaxRdTxns];
  logic [CntWidth-1:0]  ent_cnt_reg   [MaxRdTxns];
  logic [OldWidth-1:0]  ent_older_reg [MaxRdTxns];

  logic monitor_on, ar_hs, r_hs, table_full, retire_any, overflow_set;
  logic ar_due, stall_due, unexp_r, detect;
  logic [MaxRdTxns-1:0] valid_vec, head_hit, same_ar_id, first_due, last_due;
  logic [MaxRdTxns-1:0] head_oh, free_oh, first_oh, last_oh, alloc_oh;
  logic [MaxRdTxns-1:0] retire, first_beat, older_dec;
  logic [OldWidth-1:0]  new_older;
  logic [IdWidth-1:0]   first_id, last_id, det_id;
  logic [4:0]           det_cause;

  function automatic logic [MaxRdTxns-1:0] lowest_one(input logic [MaxRdTxns-1:0] v);
    lowest_one = '0;
    for (int i = int'(MaxRdTxns) - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_one    = '0;
        lowest_one[i] = 1'b1;
      end
    end
  endfunction

  // Traffic is only tracked while enabled and not busy resetting the subordinate.
  assign monitor_on = guard_ena_i && (state_reg == MONITOR);
  assign ar_hs      = ar_valid && ar_ready;
  assign r_hs       = r_valid && r_ready;

  for (genvar gi = 0; gi < MaxRdTxns; gi++) begin : g_entry_comb
    assign valid_vec[gi]  = ent_valid_reg[gi];
    assign head_hit[gi]   = ent_valid_reg[gi] && (ent_older_reg[gi] == '0) && (ent_id_reg[gi] == r_id);
    assign same_ar_id[gi] = ent_valid_reg[gi] && (ent_id_reg[gi] == ar_id);
    assign first_due[gi]  = monitor_on && ent_valid_reg[gi] && (ent_phase_reg[gi] == WAIT_FIRST)
                            && (budget_arvld_rvld_i != '0) && (ent_cnt_reg[gi] == budget_arvld_rvld_i);
    assign last_due[gi]   = monitor_on && ent_valid_reg[gi] && (ent_phase_reg[gi] == IN_BURST)
                            && (budget_rvld_rlast_i != '0) && (ent_cnt_reg[gi] == budget_rvld_rlast_i);
    assign retire[gi]     = r_hs && head_oh[gi] && r_last;
    assign first_beat[gi] = r_hs && head_oh[gi] && !r_last && (ent_phase_reg[gi] == WAIT_FIRST);
    assign older_dec[gi]  = retire_any && ent_valid_reg[gi] && !retire[gi] && (ent_id_reg[gi] == r_id);
  end

  assign head_oh      = lowest_one(head_hit);
  assign free_oh      = lowest_one(~valid_vec);
  assign first_oh     = lowest_one(first_due);
  assign last_oh      = lowest_one(last_due);
  assign table_full   = &valid_vec;
  assign retire_any   = |retire;
  assign alloc_oh     = (ar_hs && !table_full) ? free_oh : '0;
  assign overflow_set = monitor_on && ar_hs && table_full;

  // Same-ID entries queued ahead of the new one; an entry retiring now no longer counts.
  always_comb begin
    new_older = '0;
    first_id  = '0;
    last_id   = '0;
    for (int i = 0; i < int'(MaxRdTxns); i++) begin
      if (same_ar_id[i] && !retire[i]) new_older = new_older + OldOne;
      if (first_oh[i]) first_id = ent_id_reg[i];
      if (last_oh[i])  last_id  = ent_id_reg[i];
    end
  end

  assign ar_due    = monitor_on && ar_valid && (budget_arvld_arrdy_i != '0) && (ar_cnt_reg == budget_arvld_arrdy_i);
  assign stall_due = monitor_on && r_valid && (budget_rvld_rrdy_i != '0) && (r_cnt_reg == budget_rvld_rrdy_i);
  assign unexp_r   = monitor_on && r_hs && !(|head_hit);

  always_comb begin
    det_cause = '0;
    det_id    = '0;
    if (ar_due) begin
      det_cause = 5'b00001;
      det_id    = ar_id;
    end else if (|first_due) begin
      det_cause = 5'b00010;
      det_id    = first_id;
    end else if (stall_due) begin
      det_cause = 5'b00100;
      det_id    = r_id;
    end else if (|last_due) begin
      det_cause = 5'b01000;
      det_id    = last_id;
    end else if (unexp_r) begin
      det_cause = 5'b10000;
      det_id    = r_id;
    end
  end

  assign detect = |det_cause;

  for (genvar gi = 0; gi < MaxRdTxns; gi++) begin : g_entry_seq
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ent_valid_reg[gi] <= 1'b0;
        ent_id_reg[gi]    <= '0;
        ent_phase_reg[gi] <= WAIT_FIRST;
        ent_cnt_reg[gi]   <= '0;
        ent_older_reg[gi] <= '0;
      end else if (!monitor_on) begin
        ent_valid_reg[gi] <= 1'b0;
        ent_phase_reg[gi] <= WAIT_FIRST;
        ent_cnt_reg[gi]   <= '0;
        ent_older_reg[gi] <= '0;
      end else if (alloc_oh[gi]) begin
        ent_valid_reg[gi] <= 1'b1;
        ent_id_reg[gi]    <= ar_id;
        ent_phase_reg[gi] <= WAIT_FIRST;
        ent_cnt_reg[gi]   <= '0;
        ent_older_reg[gi] <= new_older;
      end else if (ent_valid_reg[gi]) begin
        if (retire[gi]) begin
          ent_valid_reg[gi] <= 1'b0;
          ent_phase_reg[gi] <= WAIT_FIRST;
          ent_cnt_reg[gi]   <= '0;
          ent_older_reg[gi] <= '0;
        end else begin
          if (first_beat[gi]) begin
            ent_phase_reg[gi] <= IN_BURST;
            ent_cnt_reg[gi]   <= '0;
          end else if (ent_cnt_reg[gi] != CntMax) begin
            ent_cnt_reg[gi] <= ent_cnt_reg[gi] + CntOne;
          end
          if (older_dec[gi]) ent_older_reg[gi] <= ent_older_reg[gi] - OldOne;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_cnt_reg <= '0;
      r_cnt_reg  <= '0;
    end else begin
      if (monitor_on && ar_valid && !ar_ready) begin
        if (ar_cnt_reg != CntMax) ar_cnt_reg <= ar_cnt_reg + CntOne;
      end else begin
        ar_cnt_reg <= '0;
      end
      if (monitor_on && r_valid && !r_ready) begin
        if (r_cnt_reg != CntMax) r_cnt_reg <= r_cnt_reg + CntOne;
      end else begin
        r_cnt_reg <= '0;
      end
    end
  end

  // A fresh violation beats a same-cycle clear; otherwise the first capture sticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_reg      <= 1'b0;
      cause_reg    <= '0;
      cause_id_reg <= '0;
      overflow_reg <= 1'b0;
      detect_reg   <= 1'b0;
      state_reg    <= MONITOR;
    end else begin
      if (detect && (!irq_reg || irq_clr_i)) begin
        irq_reg      <= 1'b1;
        cause_reg    <= det_cause;
        cause_id_reg <= det_id;
      end else if (irq_clr_i) begin
        irq_reg      <= 1'b0;
        cause_reg    <= '0;
        cause_id_reg <= '0;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (irq_clr_i) begin
        overflow_reg <= 1'b0;
      end
      detect_reg <= detect;
      state_reg  <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rst_req_o  = 1'b0;
    case (state_reg)
      MONITOR: begin
        if (detect_reg) state_next = RST_REQ;
      end
      RST_REQ: begin
        rst_req_o = 1'b1;
        if (rst_stat_i) state_next = RST_WAIT;
      end
      RST_WAIT: begin
        if (!rst_stat_i) state_next = MONITOR;
      end
      default: state_next = MONITOR;
    endcase
  end

  assign irq_o      = irq_reg;
  assign cause_o    = cause_reg;
  assign cause_id_o = cause_id_reg;
  assign overflow_o = overflow_reg;

endmodule
